// File: rtl/bilinear_kernel.sv
// Three-stage bilinear interpolation kernel: horizontal blend, vertical blend, round.
// Bubble-collapsing valid/ready pipeline holding up to three beats; flush drops all in-flight beats.
module bilinear_kernel #(
    parameter int DW = 8,
    parameter int FW = 8,
    parameter int CH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FW-1:0]      fx,
    input  logic [FW-1:0]      fy,
    input  logic [CH*DW-1:0]   p00,
    input  logic [CH*DW-1:0]   p01,
    input  logic [CH*DW-1:0]   p10,
    input  logic [CH*DW-1:0]   p11,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH*DW-1:0]   out_pix,
    output logic               busy
);

    localparam int HW = DW + FW;
    localparam int VW = DW + 2 * FW;
    localparam logic [FW:0]   ONE_W = {1'b1, {FW{1'b0}}};
    localparam logic [VW-1:0] RND   = {{(VW-1){1'b0}}, 1'b1} << (2 * FW - 1);

    logic v1_q, v2_q, v3_q;
    logic en1_s, en2_s, en3_s, acc_s;
    logic [FW:0] wx_s, wy_s;
    logic [FW-1:0] fy_q;
    logic [CH-1:0][HW-1:0] top_q, top_d, bot_q, bot_d;
    logic [CH-1:0][VW-1:0] vsum_q, vsum_d;
    logic [CH-1:0][DW-1:0] pix_q, pix_d;

    // Handshake: each stage advances when it is empty or the stage after it advances.
    always_comb begin
        en3_s = !v3_q || out_ready;
        en2_s = !v2_q || en3_s;
        en1_s = !v1_q || en2_s;
        acc_s = in_valid && en1_s && !flush;
    end

    assign in_ready  = en1_s;
    assign out_valid = v3_q;
    assign out_pix   = pix_q;
    assign busy      = v1_q || v2_q || v3_q;

    // Datapath: products are sized to the stage width because every weighted sum fits exactly.
    always_comb begin
        wx_s = ONE_W - {1'b0, fx};
        wy_s = ONE_W - {1'b0, fy_q};
        top_d  = '0;
        bot_d  = '0;
        vsum_d = '0;
        pix_d  = '0;
        for (int c = 0; c < CH; c++) begin
            top_d[c]  = HW'(p00[c*DW +: DW]) * HW'(wx_s) + HW'(p01[c*DW +: DW]) * HW'(fx);
            bot_d[c]  = HW'(p10[c*DW +: DW]) * HW'(wx_s) + HW'(p11[c*DW +: DW]) * HW'(fx);
            vsum_d[c] = VW'(top_q[c]) * VW'(wy_s) + VW'(bot_q[c]) * VW'(fy_q);
            pix_d[c]  = DW'((vsum_q[c] + RND) >> (2 * FW));
        end
    end

    // Stage valid bits; flush empties the whole pipeline regardless of out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (flush) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            if (en1_s) v1_q <= acc_s;
            if (en2_s) v2_q <= v1_q;
            if (en3_s) v3_q <= v2_q;
        end
    end

    // Stage data registers load only on a valid upstream beat, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q  <= '0;
            bot_q  <= '0;
            fy_q   <= '0;
            vsum_q <= '0;
            pix_q  <= '0;
        end else begin
            if (en1_s && acc_s) begin
                top_q <= top_d;
                bot_q <= bot_d;
                fy_q  <= fy;
            end
            if (en2_s && v1_q && !flush) vsum_q <= vsum_d;
            if (en3_s && v2_q && !flush) pix_q  <= pix_d;
        end
    end

endmodule

// File: tb/tb_bilinear_kernel.sv
// Directed bench for bilinear_kernel with DW=8, FW=8, CH=2 and hand-computed expectations.
module tb_bilinear_kernel;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  fx;
    logic [7:0]  fy;
    logic [15:0] p00, p01, p10, p11;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pix;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bilinear_kernel #(.DW(8), .FW(8), .CH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fx        (fx),
        .fy        (fy),
        .p00       (p00),
        .p01       (p01),
        .p10       (p10),
        .p11       (p11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] fxv, input logic [7:0] fyv,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        fx  = fxv;
        fy  = fyv;
        p00 = a;
        p01 = b;
        p10 = c;
        p11 = d;
    endtask

    // One beat through an idle pipeline; checks latency and value.
    task automatic run_beat(input logic [7:0] fxv, input logic [7:0] fyv,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [15:0] exp, input string tag);
        int n;
        drive(fxv, fyv, a, b, c, d);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_pix"}, 32'(out_pix), 32'(exp));
        @(posedge clk); #1;
    endtask

    logic [15:0] sb [6];
    int sent, got, seen;
    logic acc, fire;

    initial begin
        clk = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(8'd0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pix",   32'(out_pix),   32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);

        // Corners and rounding
        run_beat(8'd0, 8'd0, 16'h37C4, 16'($urandom), 16'($urandom), 16'($urandom), 16'h37C4, "corner00");
        run_beat(8'd128, 8'd128, 16'h0000, 16'h6464, 16'hC8C8, 16'hFFFF, 16'h8B8B, "mid");
        run_beat(8'd255, 8'd255, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, "max");
        run_beat(8'd255, 8'd0, 16'h0000, 16'hFFFF, 16'($urandom), 16'($urandom), 16'hFEFE, "fx255");
        run_beat(8'd128, 8'd0, 16'h0A0A, 16'h1515, 16'h0000, 16'h0000, 16'h1010, "half_up_h");
        run_beat(8'd0, 8'd128, 16'h0102, 16'h0000, 16'h0203, 16'h0000, 16'h0203, "half_up_v");

        // Stall: six beats, out_ready low in cycles 2-7
        for (int k = 0; k < 6; k++) sb[k] = 16'h1111 * 16'(k + 1);
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_ready = (cyc >= 2 && cyc <= 7) ? 1'b0 : 1'b1;
            in_valid  = (sent < 6) ? 1'b1 : 1'b0;
            drive(8'd0, 8'd0, (sent < 6) ? sb[sent] : 16'h0000, 16'($urandom), 16'($urandom), 16'($urandom));
            #1;
            if (cyc == 2) chk("stall_ready_not_full", 32'(in_ready), 32'h1);
            if (cyc >= 3 && cyc <= 7) begin
                chk("stall_in_ready", 32'(in_ready),  32'h0);
                chk("stall_valid",    32'(out_valid), 32'h1);
                chk("stall_pix",      32'(out_pix),   32'(sb[0]));
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                chk("stream_order", 32'(out_pix), (got < 6) ? 32'(sb[got]) : 32'hDEAD);
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        chk("stream_count", 32'(got), 32'd6);
        in_valid = 1'b0;

        // Flush with two beats in flight and a beat offered in the flush cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(8'd0, 8'd0, 16'hA1A1, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        drive(8'd0, 8'd0, 16'hB2B2, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        flush = 1'b1;
        drive(8'd0, 8'd0, 16'hC3C3, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy",  32'(busy),      32'h0);
        chk("flush_valid", 32'(out_valid), 32'h0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_output", 32'(seen), 32'd0);
        run_beat(8'd0, 8'd0, 16'hD4D4, 16'h0000, 16'h0000, 16'h0000, 16'hD4D4, "after_flush");

        // Asynchronous reset with a full, stalled pipeline
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(8'd0, 8'd0, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("prerst_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    32'(out_valid), 32'h0);
        chk("arst_pix",      32'(out_pix),   32'h0);
        chk("arst_busy",     32'(busy),      32'h0);
        chk("arst_in_ready", 32'(in_ready),  32'h1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_beat(8'd128, 8'd128, 16'h0000, 16'h6464, 16'hC8C8, 16'hFFFF, 16'h8B8B, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
